dsram_req_ctrl: RTL and testbench

//  Sequences MEM-stage data accesses onto the SRAM-like data bus (req/addr_ok/data_ok).

---
 rtl/dsram_req_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dsram_req_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_req_ctrl.sv
// dsram_req_ctrl: MEM-stage data request sequencer for an SRAM-like bus.
// A single hold register captures one access and presents it on the bus
// until the address phase is accepted. In-flight transactions are counted
// so that data_ok beats can be routed back to MEM/WB in issue order. On a
// pipeline flush, every transaction issued before the flush, including one
// still waiting in the hold register, is marked for silent discard.
module dsram_req_ctrl #(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        reset,

  // MEM-stage request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,

  // MEM/WB response side
  output logic        resp_valid,
  output logic [31:0] resp_rdata,

  // SRAM-like data bus
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Hold register: the one access currently owned by the bus address phase.
  logic        hold_valid_q, hold_valid_d;
  logic        hold_kill_q,  hold_kill_d;
  logic        hold_wr_q,    hold_wr_d;
  logic [1:0]  hold_size_q,  hold_size_d;
  logic [3:0]  hold_wstrb_q, hold_wstrb_d;
  logic [31:0] hold_addr_q,  hold_addr_d;
  logic [31:0] hold_wdata_q, hold_wdata_d;

  // In-flight bookkeeping: transactions past addr_ok, and how many of the
  // oldest ones must be swallowed when their data_ok arrives.
  logic [CNT_W-1:0] outst_cnt_q,   outst_cnt_d;
  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;

  // Handshake qualifiers for this cycle.
  logic req_fire;
  logic addr_fire;
  logic data_fire;
  logic discard_inc;
  logic discard_dec;

  // Bus side is a direct view of the hold register, so it cannot change
  // while data_req is waiting for addr_ok.
  assign data_req   = hold_valid_q;
  assign data_wr    = hold_wr_q;
  assign data_size  = hold_size_q;
  assign data_wstrb = hold_wstrb_q;
  assign data_addr  = hold_addr_q;
  assign data_wdata = hold_wdata_q;

  // Accept only into an empty hold slot, never during a flush, and only
  // while there is room for one more in-flight transaction.
  assign req_ready = !reset && !hold_valid_q && !flush && (outst_cnt_q < MAX_CNT);
  assign req_fire  = req_valid && req_ready;

  assign addr_fire = hold_valid_q && data_addr_ok;
  // A data_ok with nothing outstanding belongs to no transaction of ours.
  assign data_fire = data_data_ok && (outst_cnt_q != '0);

  assign discard_dec = data_fire && (discard_cnt_q != '0);
  assign discard_inc = addr_fire && hold_kill_q;

  // Responses pass straight through in the data_ok cycle unless the oldest
  // transaction is marked dead or a flush kills it on arrival.
  assign resp_valid = !reset && data_fire && (discard_cnt_q == '0) && !flush;
  assign resp_rdata = resp_valid ? data_rdata : '0;

  // Next-state for the hold register: load on accept, release on addr_ok.
  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to remember it.
    hold_valid_d = hold_valid_q;
    hold_kill_d  = hold_kill_q;
    hold_wr_d    = hold_wr_q;
    hold_size_d  = hold_size_q;
    hold_wstrb_d = hold_wstrb_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;

    if (req_fire) begin
      hold_valid_d = 1'b1;
      hold_wr_d    = req_wr;
      hold_size_d  = req_size;
      hold_wstrb_d = req_wstrb;
      hold_addr_d  = req_addr;
      hold_wdata_d = req_wdata;
    end else if (addr_fire) begin
      hold_valid_d = 1'b0;
    end

    // A held request cannot be withdrawn from the bus, so a flush only
    // marks it; the mark turns into a discard slot when addr_ok arrives.
    // A flush coinciding with addr_ok is covered by the discard counter
    // reload below instead.
    if (addr_fire) begin
      hold_kill_d = 1'b0;
    end else if (flush && hold_valid_q) begin
      hold_kill_d = 1'b1;
    end
  end

  // Next-state for the in-flight and discard counters.
  always_comb begin
    outst_cnt_d = outst_cnt_q;
    if (addr_fire && !data_fire) begin
      outst_cnt_d = outst_cnt_q + CNT_ONE;
    end else if (!addr_fire && data_fire) begin
      outst_cnt_d = outst_cnt_q - CNT_ONE;
    end

    discard_cnt_d = discard_cnt_q;
    if (flush) begin
      // Everything in flight after this cycle's moves predates the flush.
      discard_cnt_d = outst_cnt_d;
    end else if (discard_inc && !discard_dec) begin
      discard_cnt_d = discard_cnt_q + CNT_ONE;
    end else if (!discard_inc && discard_dec) begin
      discard_cnt_d = discard_cnt_q - CNT_ONE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge value of the others, independent of statement order.
    if (reset) begin
      hold_valid_q  <= 1'b0;
      hold_kill_q   <= 1'b0;
      hold_wr_q     <= 1'b0;
      hold_size_q   <= '0;
      hold_wstrb_q  <= '0;
      hold_addr_q   <= '0;
      hold_wdata_q  <= '0;
      outst_cnt_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_kill_q   <= hold_kill_d;
      hold_wr_q     <= hold_wr_d;
      hold_size_q   <= hold_size_d;
      hold_wstrb_q  <= hold_wstrb_d;
      hold_addr_q   <= hold_addr_d;
      hold_wdata_q  <= hold_wdata_d;
      outst_cnt_q   <= outst_cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  // Structural invariants of the bookkeeping, checked in simulation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (outst_cnt_q <= MAX_CNT);
      assert (discard_cnt_q <= outst_cnt_q);
      assert (!hold_kill_q || hold_valid_q);
    end
  end

endmodule

// File: tb/tb_dsram_req_ctrl.sv
// Testbench for dsram_req_ctrl. The bench plays both the MEM stage and the
// bus slave. Its reference model keeps the held access plus an in-order
// queue of issued transactions, each tagged live or dead; a flush marks
// everything issued or held as dead, and data_ok pops the oldest entry.
module tb_dsram_req_ctrl;

  localparam int MAX_OUTST = 2;
  localparam int CNT_W     = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [3:0]  req_wstrb;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  dsram_req_ctrl #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_size     (req_size),
    .req_wstrb    (req_wstrb),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  // Reference model state
  acc_t m_hold       = '0;
  bit   m_hold_valid = 1'b0;
  bit   m_hold_live  = 1'b0;
  bit   m_live_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req_valid    = 1'b0;
    req_wr       = 1'b0;
    req_size     = 2'd0;
    req_wstrb    = 4'd0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    flush        = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
  endtask

  task automatic set_req(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_wr    = wr;
    req_size  = sz;
    req_wstrb = st;
    req_addr  = a;
    req_wdata = d;
  endtask

  // One clock cycle: inputs were set by the caller; compare outputs
  // mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    bit exp_ready;
    bit exp_resp;
    int dead;
    @(negedge clk);
    #1;
    exp_ready = !reset && !m_hold_valid && !flush && (m_live_q.size() < MAX_OUTST);
    exp_resp  = !reset && data_data_ok && (m_live_q.size() > 0) && m_live_q[0] && !flush;
    dead = 0;
    foreach (m_live_q[i]) if (!m_live_q[i]) dead++;

    check("req_ready",   32'(req_ready),  32'(exp_ready));
    check("data_req",    32'(data_req),   32'(m_hold_valid));
    check("data_wr",     32'(data_wr),    32'(m_hold.wr));
    check("data_size",   32'(data_size),  32'(m_hold.size));
    check("data_wstrb",  32'(data_wstrb), 32'(m_hold.wstrb));
    check("data_addr",   data_addr,       m_hold.addr);
    check("data_wdata",  data_wdata,      m_hold.wdata);
    check("resp_valid",  32'(resp_valid), 32'(exp_resp));
    if (exp_resp) check("resp_rdata", resp_rdata, data_rdata);
    if (reset)    check("resp_rdata_rst", resp_rdata, 32'd0);
    check("outst_cnt",   32'(dut.outst_cnt_q),   32'(m_live_q.size()));
    check("discard_cnt", 32'(dut.discard_cnt_q), 32'(dead));
    check("hold_kill",   32'(dut.hold_kill_q),   32'(m_hold_valid && !m_hold_live));

    @(posedge clk);
    if (reset) begin
      m_live_q.delete();
      m_hold_valid = 1'b0;
      m_hold_live  = 1'b0;
      m_hold       = '0;
    end else begin
      if (data_data_ok && m_live_q.size() > 0) void'(m_live_q.pop_front());
      if (data_addr_ok && m_hold_valid) begin
        m_live_q.push_back(m_hold_live);
        m_hold_valid = 1'b0;
      end
      if (flush) begin
        foreach (m_live_q[i]) m_live_q[i] = 1'b0;
        m_hold_live = 1'b0;
      end
      if (req_valid && exp_ready) begin
        m_hold_valid = 1'b1;
        m_hold_live  = 1'b1;
        m_hold       = '{wr: req_wr, size: req_size, wstrb: req_wstrb,
                         addr: req_addr, wdata: req_wdata};
      end
    end
    #1;
  endtask

  // Accept a word load and let the bus take its address on the next cycle.
  task automatic issue_load(input logic [31:0] a);
    idle();
    set_req(1'b0, 2'd2, 4'hf, a, 32'd0);
    cycle();
    idle();
    data_addr_ok = 1'b1;
    cycle();
    idle();
  endtask

  initial begin
    // Reset state
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    reset = 1'b0;
    cycle();

    // Load, no wait: accept at N, addr_ok at N+1, data_ok at N+3
    set_req(1'b0, 2'd2, 4'hf, 32'h0000_1000, 32'd0);
    cycle();
    idle(); data_addr_ok = 1'b1; cycle();
    idle(); cycle();
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; cycle();
    idle(); cycle();

    // Address stall: addr_ok low for 4 cycles while a new request waits
    set_req(1'b1, 2'd1, 4'b0011, 32'h0000_2002, 32'hABCD_ABCD);
    cycle();
    set_req(1'b0, 2'd2, 4'hf, 32'h0000_3000, 32'd0);
    repeat (4) cycle();
    idle(); data_addr_ok = 1'b1; cycle();
    idle(); data_data_ok = 1'b1; data_rdata = 32'h0; cycle();
    idle(); cycle();

    // Outstanding limit: two in flight blocks acceptance until one returns
    issue_load(32'h0000_4000);
    issue_load(32'h0000_4004);
    set_req(1'b0, 2'd2, 4'hf, 32'h0000_4008, 32'd0);
    repeat (2) cycle();
    data_data_ok = 1'b1; data_rdata = 32'h1111_1111; cycle();
    data_data_ok = 1'b0; cycle();
    idle(); data_addr_ok = 1'b1; cycle();
    idle(); data_data_ok = 1'b1; data_rdata = 32'h2222_2222; cycle();
    data_rdata = 32'h3333_3333; cycle();
    idle(); cycle();

    // Flush with two outstanding: both responses dropped, next load served
    issue_load(32'h0000_5000);
    issue_load(32'h0000_5004);
    flush = 1'b1; cycle();
    idle(); data_data_ok = 1'b1; data_rdata = 32'hAAAA_AAAA; cycle();
    data_rdata = 32'hBBBB_BBBB; cycle();
    issue_load(32'h0000_6000);
    data_data_ok = 1'b1; data_rdata = 32'h0000_0055; cycle();
    idle(); cycle();

    // Flush while held: request still issued later, its data dropped
    set_req(1'b0, 2'd0, 4'b0001, 32'h0000_7001, 32'd0);
    cycle();
    idle(); flush = 1'b1; cycle();
    idle(); repeat (2) cycle();
    data_addr_ok = 1'b1; cycle();
    idle(); data_data_ok = 1'b1; data_rdata = 32'h7777_7777; cycle();
    idle(); cycle();
    check("discard_end", 32'(dut.discard_cnt_q), 32'd0);

    // Flush in the same cycle as a live data_ok: response killed
    issue_load(32'h0000_8000);
    flush = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0000_0088; cycle();
    idle(); cycle();

    // Flush in the same cycle as addr_ok: that transaction is discarded
    set_req(1'b0, 2'd2, 4'hf, 32'h0000_8800, 32'd0);
    cycle();
    idle(); data_addr_ok = 1'b1; flush = 1'b1; cycle();
    idle(); data_data_ok = 1'b1; data_rdata = 32'h0000_0089; cycle();
    idle(); cycle();

    // Stray data_ok with nothing outstanding is ignored
    data_data_ok = 1'b1; data_rdata = 32'h0000_0099; cycle();
    idle(); cycle();

    // Reset with two outstanding clears everything
    issue_load(32'h0000_9000);
    issue_load(32'h0000_9004);
    reset = 1'b1; cycle();
    reset = 1'b0; cycle();
    check("rst_outst",   32'(dut.outst_cnt_q),   32'd0);
    check("rst_discard", 32'(dut.discard_cnt_q), 32'd0);
    check("rst_data_req", 32'(data_req),         32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      req_valid    = ($urandom_range(0, 99) < 60);
      req_wr       = 1'($urandom);
      req_size     = 2'($urandom_range(0, 2));
      req_wstrb    = 4'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      data_addr_ok = ($urandom_range(0, 99) < 50);
      data_data_ok = (m_live_q.size() > 0) && ($urandom_range(0, 99) < 40);
      data_rdata   = $urandom;
      flush        = ($urandom_range(0, 99) < 5);
      reset        = ($urandom_range(0, 999) < 3);
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
